// File: rtl/mon_pkg.sv
// mon_pkg: shared state encoding, default frame width and count-width helper for the monitor sender
package mon_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, GAP, PARITY} state_t;
  localparam int MON_FRAME_W_DEFAULT = 40;
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/mon_sync_fifo.sv
// mon_sync_fifo: DEPTH x W synchronous FIFO with occupancy count and guarded push/pop
module mon_sync_fifo
  import mon_pkg::*;
#(
  parameter int W = MON_FRAME_W_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                   mon_clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rp];
  always_ff @(posedge mon_clk)
    if (do_push) mem[wp] <= wdata;
  always_ff @(posedge mon_clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/mon_frame_sender.sv
// mon_frame_sender: FIFO-buffered framed serial sender (start bit, MSB-first data, idle gap); MON_SENDER_PARITY_EN adds an even-parity bit
module mon_frame_sender
  import mon_pkg::*;
#(
  parameter int FRAME_W = MON_FRAME_W_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                        mon_clk,
  input  logic                        reset_n,
  input  logic [FRAME_W-1:0]          in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        from_mon,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int BW = $clog2(FRAME_W > GAP_CYCLES ? FRAME_W : GAP_CYCLES) + 1;
  state_t state, state_n;
  logic [FRAME_W-1:0] shift, shift_n, head;
  logic [BW-1:0] cnt, cnt_n;
  logic pop, full, empty, from_mon_n, tx_done_n;
  mon_sync_fifo #(.W(FRAME_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .mon_clk(mon_clk),
    .reset_n(reset_n),
    .push(in_valid),
    .pop(pop),
    .wdata(in_data),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  assign in_ready = !full;
  assign busy = (state != IDLE) || (fifo_count != '0);
`ifdef MON_SENDER_PARITY_EN
  logic par, par_n;
  always_ff @(posedge mon_clk or negedge reset_n)
    if (!reset_n) par <= 1'b0;
    else par <= par_n;
  assign par_n = pop ? ^head : par;
`endif
  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n = cnt;
    pop = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        shift_n = head;
        state_n = START;
      end
      START: begin
        state_n = DATA;
        cnt_n = BW'(FRAME_W - 1);
      end
      DATA: begin
        shift_n = shift << 1;
        cnt_n = cnt - 1'b1;
        if (cnt == '0) begin
`ifdef MON_SENDER_PARITY_EN
          state_n = PARITY;
`else
          state_n = GAP;
          cnt_n = BW'(GAP_CYCLES - 1);
`endif
        end
      end
      PARITY: begin
        state_n = GAP;
        cnt_n = BW'(GAP_CYCLES - 1);
      end
      GAP: begin
        cnt_n = cnt - 1'b1;
        if (cnt == '0) begin
          pop = !empty;
          shift_n = empty ? shift : head;
          state_n = empty ? IDLE : START;
        end
      end
      default: state_n = IDLE;
    endcase
    // Outputs are registered, so compute the line value for the state being entered
    from_mon_n = (state_n == START) || (state_n == DATA && shift_n[FRAME_W-1]);
`ifdef MON_SENDER_PARITY_EN
    from_mon_n = from_mon_n || (state_n == PARITY && par_n);
`endif
    tx_done_n = state_n == GAP && state != GAP;
  end
  always_ff @(posedge mon_clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      shift <= '0;
      cnt <= '0;
      from_mon <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      cnt <= cnt_n;
      from_mon <= from_mon_n;
      tx_done <= tx_done_n;
    end
endmodule

// File: tb/tb_mon_frame_sender.sv
// tb_mon_frame_sender: scoreboard bench for the 40-bit sender plus a vector table for an 8-bit instance
module tb_mon_frame_sender;
  localparam int FW = 40;
  localparam int GAP = 2;
`ifdef MON_SENDER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int PER = 1 + FW + GAP + PB;
  logic mon_clk = 1'b0;
  logic reset_n = 1'b0;
  logic [FW-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready, from_mon, busy, tx_done;
  logic [2:0] fifo_count;
  logic [7:0] d8 = '0;
  logic v8 = 1'b0;
  logic r8, fm8, b8, td8;
  logic [1:0] c8;
  mon_frame_sender #(.FRAME_W(FW), .FIFO_DEPTH(4), .GAP_CYCLES(GAP)) dut (
    .mon_clk(mon_clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .from_mon(from_mon), .busy(busy), .tx_done(tx_done),
    .fifo_count(fifo_count)
  );
  mon_frame_sender #(.FRAME_W(8), .FIFO_DEPTH(2), .GAP_CYCLES(1)) dut8 (
    .mon_clk(mon_clk), .reset_n(reset_n), .in_data(d8), .in_valid(v8),
    .in_ready(r8), .from_mon(fm8), .busy(b8), .tx_done(td8), .fifo_count(c8)
  );
  always #5 mon_clk = ~mon_clk;
  int cyc = 0;
  always @(posedge mon_clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  logic [FW-1:0] sbq[$];
  int starts[$];
  int td_cyc = -1, frames = 0;
  int ms = 0, nb = 0, gc = 0;
  logic [FW-1:0] sh = '0;
  // Serial line decoder: rebuilds frames and checks framing, gap and tx_done timing
  always @(negedge mon_clk) begin
    if (!reset_n) begin
      ms = 0;
      nb = 0;
      gc = 0;
    end else case (ms)
      0: begin
        chk("tx_done_idle", 64'(tx_done), 64'(0));
        if (from_mon) begin
          starts.push_back(cyc);
          ms = 1;
          nb = 0;
        end
      end
      1: begin
        chk("tx_done_data", 64'(tx_done), 64'(0));
        sh = {sh[FW-2:0], from_mon};
        nb++;
        if (nb == FW) begin
          gc = 0;
`ifdef MON_SENDER_PARITY_EN
          ms = 2;
`else
          ms = 3;
`endif
        end
      end
`ifdef MON_SENDER_PARITY_EN
      2: begin
        chk("parity", 64'(from_mon), 64'(^sh));
        ms = 3;
      end
`endif
      default: begin
        chk("gap_low", 64'(from_mon), 64'(0));
        chk("tx_done_gap", 64'(tx_done), 64'(gc == 0));
        if (gc == 0) td_cyc = cyc;
        gc++;
        if (gc == GAP) begin
          if (sbq.size() == 0) chk("unexpected_frame", 64'(sh), 64'(0));
          else chk("frame", 64'(sh), 64'(sbq.pop_front()));
          frames++;
          ms = 0;
        end
      end
    endcase
  end
  task automatic push(input logic [FW-1:0] d, output int acc);
    int n = 0;
    in_data = d;
    in_valid = 1'b1;
    acc = -1;
    while (acc < 0) begin
      @(negedge mon_clk);
      if (in_ready) begin
        acc = cyc;
        sbq.push_back(d);
      end else if (++n > 300) begin
        chk("push_timeout", 64'(1), 64'(0));
        acc = 0;
      end
      @(posedge mon_clk);
      #1;
    end
  endtask
  task automatic wait_frames(input int n);
    int k = 0;
    while (frames < n && k < 2000) begin
      @(negedge mon_clk);
      k++;
    end
    chk("frames_seen", 64'(frames), 64'(n));
  endtask
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 500) begin
      @(negedge mon_clk);
      k++;
    end
    chk("idle", 64'(busy), 64'(0));
    @(posedge mon_clk);
    #1;
  endtask
  typedef struct {logic v; logic [7:0] d; logic fm; logic td; logic bz;} vec_t;
  vec_t tab[14];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int p, p0, p5, hi, k;
    logic [13:0] fm_seq, td_seq, bz_seq;
    fm_seq = 14'h040C;
`ifdef MON_SENDER_PARITY_EN
    td_seq = 14'h1000;
    bz_seq = 14'h1FFE;
`else
    td_seq = 14'h0800;
    bz_seq = 14'h0FFE;
`endif
    for (int i = 0; i < 14; i++) tab[i] = '{i == 0, 8'h81, fm_seq[i], td_seq[i], bz_seq[i]};
    repeat (3) @(negedge mon_clk);
    chk("rst_from_mon", 64'(from_mon), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_tx_done", 64'(tx_done), 64'(0));
    chk("rst_count", 64'(fifo_count), 64'(0));
    chk("rst8_ready_count", 64'({r8, c8}), 64'(3'b100));
    @(posedge mon_clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge mon_clk);
    #1;
    push(40'hA5_0000_0F0F, p);
    in_valid = 1'b0;
    wait_frames(1);
    chk("first_start_cycle", 64'(starts.size() > 0 ? starts[0] : -1), 64'(p + 2));
    chk("tx_done_cycle", 64'(td_cyc), 64'(p + 3 + FW + PB));
    wait_idle();
    starts.delete();
    frames = 0;
    push(40'h1, p0);
    push(40'h3, p);
    for (int i = 0; i < 3; i++) push(FW'({$urandom(), $urandom()}), p);
    in_data = FW'({$urandom(), $urandom()});
    @(negedge mon_clk);
    chk("full_in_ready", 64'(in_ready), 64'(0));
    chk("full_count", 64'(fifo_count), 64'(4));
    chk("full_busy", 64'(busy), 64'(1));
    push(in_data, p5);
    in_valid = 1'b0;
    chk("held_accept_cycle", 64'(p5), 64'(p0 + 2 + PER));
    wait_frames(6);
    chk("burst_first_start", 64'(starts.size() > 0 ? starts[0] : -1), 64'(p0 + 2));
    for (int i = 1; i < 6; i++)
      chk("frame_period", 64'(starts.size() > i ? starts[i] - starts[i-1] : -1), 64'(PER));
    wait_idle();
    for (int i = 0; i < 14; i++) begin
      v8 = tab[i].v;
      d8 = tab[i].d;
      @(negedge mon_clk);
      chk($sformatf("w8_from_mon[%0d]", i), 64'(fm8), 64'(tab[i].fm));
      chk($sformatf("w8_tx_done[%0d]", i), 64'(td8), 64'(tab[i].td));
      chk($sformatf("w8_busy[%0d]", i), 64'(b8), 64'(tab[i].bz));
      @(posedge mon_clk);
      #1;
    end
    push({FW{1'b1}}, p);
    push({FW{1'b1}}, p);
    in_valid = 1'b0;
    k = 0;
    while (!(ms == 1 && nb == 20) && k < 200) begin
      @(negedge mon_clk);
      #1;
      k++;
    end
    chk("reached_bit20", 64'(nb), 64'(20));
    chk("line_high_before_reset", 64'(from_mon), 64'(1));
    #2 reset_n = 1'b0;
    sbq.delete();
    #1;
    chk("mid_rst_from_mon", 64'(from_mon), 64'(0));
    chk("mid_rst_count", 64'(fifo_count), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge mon_clk);
    #1 reset_n = 1'b1;
    hi = 0;
    repeat (60) begin
      @(negedge mon_clk);
      hi |= int'(from_mon);
    end
    chk("no_residual_bits", 64'(hi), 64'(0));
    chk("post_reset_busy", 64'(busy), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
